// File: rtl/mac_array_ctrl.sv
// Sequencer for the 2-D MAC array: issues weight then activation SRAM reads,
// skews inst/data per row toward the west edge, and counts output valids.
module mac_array_ctrl #(
  parameter int unsigned row    = 8,
  parameter int unsigned col    = 8,
  parameter int unsigned bw     = 4,
  parameter int unsigned addr_w = 11,
  parameter int unsigned cnt_w  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   w_base,
  input  logic [addr_w-1:0]   x_base,
  input  logic [cnt_w-1:0]    n_x,
  output logic                sram_cen,
  output logic [addr_w-1:0]   sram_addr,
  input  logic [row*bw-1:0]   sram_q,
  output logic [row*bw-1:0]   in_w,
  output logic [2*row-1:0]    inst_w,
  input  logic [col-1:0]      valid_in,
  output logic                busy,
  output logic                done
);

  localparam logic [cnt_w-1:0] last_w = cnt_w'(col - 1);

  typedef enum logic [2:0] {
    st_idle, st_load, st_exec, st_drain, st_done
  } state_t;

  state_t              state, next_state;
  logic [cnt_w-1:0]    idx, idx_d;
  logic [cnt_w-1:0]    n_x_r, n_x_d;
  logic [cnt_w-1:0]    out_cnt, out_cnt_d;
  logic [addr_w-1:0]   x_base_r, x_base_d;
  logic [addr_w-1:0]   addr_d;
  logic                cen_d, busy_d, done_d;
  logic                unused_valid;

  // Only the last column's valid marks a finished output vector.
  assign unused_valid = ^valid_in[col-2:0];

  always_comb begin
    next_state = state;
    idx_d      = idx;
    n_x_d      = n_x_r;
    x_base_d   = x_base_r;
    out_cnt_d  = out_cnt;
    addr_d     = sram_addr;
    cen_d      = 1'b1;

    if ((state == st_load || state == st_exec || state == st_drain) &&
        valid_in[col-1] && (out_cnt != n_x_r)) begin
      out_cnt_d = out_cnt + cnt_w'(1);
    end

    case (state)
      st_idle: begin
        if (start) begin
          next_state = st_load;
          idx_d      = '0;
          n_x_d      = n_x;
          x_base_d   = x_base;
          out_cnt_d  = '0;
          cen_d      = 1'b0;
          addr_d     = w_base;
        end
      end
      st_load: begin
        if (idx == last_w) begin
          idx_d = '0;
          if (n_x_r == '0) begin
            next_state = st_drain;
          end else begin
            next_state = st_exec;
            cen_d      = 1'b0;
            addr_d     = x_base_r;
          end
        end else begin
          idx_d  = idx + cnt_w'(1);
          cen_d  = 1'b0;
          addr_d = sram_addr + addr_w'(1);
        end
      end
      st_exec: begin
        if (cnt_w'(idx + cnt_w'(1)) == n_x_r) begin
          next_state = st_drain;
          idx_d      = '0;
        end else begin
          idx_d  = idx + cnt_w'(1);
          cen_d  = 1'b0;
          addr_d = sram_addr + addr_w'(1);
        end
      end
      st_drain: begin
        if ((out_cnt == n_x_r) && (inst_w == '0)) next_state = st_done;
      end
      st_done: next_state = st_idle;
      default: next_state = st_idle;
    endcase

    busy_d = (next_state == st_load) || (next_state == st_exec) ||
             (next_state == st_drain);
    done_d = (next_state == st_done);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= st_idle;
      idx       <= '0;
      n_x_r     <= '0;
      x_base_r  <= '0;
      out_cnt   <= '0;
      sram_cen  <= 1'b1;
      sram_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inst_w    <= '0;
    end else begin
      state     <= next_state;
      idx       <= idx_d;
      n_x_r     <= n_x_d;
      x_base_r  <= x_base_d;
      out_cnt   <= out_cnt_d;
      sram_cen  <= cen_d;
      sram_addr <= addr_d;
      busy      <= busy_d;
      done      <= done_d;
      // Row 0 holds the raw inst (read type of the previous cycle); row r is row r-1 delayed.
      inst_w    <= {inst_w[2*row-3:0], state == st_exec, state == st_load};
    end
  end

  // Per-row data skew: row r's slice is masked by the raw inst, then delayed r cycles.
  for (genvar r = 0; r < row; r++) begin : g_row
    logic [bw-1:0] head;
    assign head = (inst_w[1:0] != 2'b00) ? sram_q[bw*r +: bw] : '0;

    if (r == 0) begin : g_direct
      assign in_w[bw-1:0] = head;
    end else begin : g_skew
      logic [bw-1:0] chain [r];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < r; k++) chain[k] <= '0;
        end else begin
          chain[0] <= head;
          for (int k = 1; k < r; k++) chain[k] <= chain[k-1];
        end
      end
      assign in_w[bw*r +: bw] = chain[r-1];
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed self-checking bench for mac_array_ctrl (row=col=8, bw=4) with a
// one-cycle-latency SRAM model and a bottom-row valid stub.
module tb_mac_array_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] w_base, x_base;
  logic [7:0]  n_x;
  logic        sram_cen;
  logic [10:0] sram_addr;
  logic [31:0] sram_q = '0;
  logic [31:0] in_w;
  logic [15:0] inst_w;
  logic [7:0]  valid_in;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  mac_array_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .n_x(n_x),
    .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_q(sram_q),
    .in_w(in_w), .inst_w(inst_w), .valid_in(valid_in),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mem_val(input int a, input int r);
    return 4'(a * 3 + r * 5 + 1);
  endfunction

  function automatic logic [31:0] pack_q(input int a);
    logic [31:0] q;
    q = '0;
    for (int r = 0; r < 8; r++) q[4*r +: 4] = mem_val(a, r);
    return q;
  endfunction

  // SRAM stub: data for the address read appears one cycle later.
  always @(posedge clk) begin
    if (sram_cen == 1'b0) sram_q <= pack_q(int'(sram_addr));
  end

  // Read kind issued in cycle t: 1 weight, 2 activation, 0 none.
  function automatic int rd_kind(input int t, input int nx);
    if (t >= 1 && t <= 8) return 1;
    if (t >= 9 && t <= 8 + nx) return 2;
    return 0;
  endfunction

  function automatic int rd_addr(input int t, input int wb, input int xb, input int nx);
    if (t >= 1 && t <= 8) return (wb + t - 1) % 2048;
    if (t >= 9 && t <= 8 + nx) return (xb + t - 9) % 2048;
    return -1;
  endfunction

  function automatic int hold_addr(input int c, input int wb, input int xb, input int nx);
    for (int t = c; t >= 1; t--) begin
      if (rd_addr(t, wb, xb, nx) >= 0) return rd_addr(t, wb, xb, nx);
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_cycle(input int c, input int wb, input int xb, input int nx);
    logic [31:0] e_in;
    logic [15:0] e_inst;
    int          t, k;
    e_in   = '0;
    e_inst = '0;
    for (int r = 0; r < 8; r++) begin
      t = c - 1 - r;
      k = rd_kind(t, nx);
      e_inst[2*r +: 2] = 2'(k);
      if (k != 0) e_in[4*r +: 4] = mem_val(rd_addr(t, wb, xb, nx), r);
    end
    chk("sram_cen", c, 32'(sram_cen), 32'(rd_addr(c, wb, xb, nx) < 0));
    chk("sram_addr", c, 32'(sram_addr), 32'(hold_addr(c, wb, xb, nx)));
    chk("inst_w", c, 32'(inst_w), 32'(e_inst));
    chk("in_w", c, in_w, e_in);
    chk("busy", c, 32'(busy), 32'(c < nx + 18));
    chk("done", c, 32'(done), 32'(c == nx + 18));
  endtask

  // One start; ign pulses a conflicting start at that cycle, abort_c raises reset.
  task automatic run(input int wb, input int xb, input int nx, input int nval,
                     input int ign, input int abort_c);
    int last, n_done;
    n_done = 0;
    @(negedge clk);
    w_base = 11'(wb); x_base = 11'(xb); n_x = 8'(nx); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last = (abort_c > 0) ? abort_c : nx + 20;
    for (int c = 1; c <= last; c++) begin
      check_cycle(c, wb, xb, nx);
      if (done) n_done++;
      start = (c == ign);
      if (c == ign) begin
        w_base = 11'h555; x_base = 11'h2AA; n_x = 8'd9;
      end
      valid_in = {1'(c >= 14 && c < 14 + nval), 7'h2A};
      if (c == abort_c) reset = 1'b1;
      @(negedge clk);
    end
    start    = 1'b0;
    valid_in = '0;
    if (abort_c > 0) begin
      chk("abort_inst_w", abort_c + 1, 32'(inst_w), 32'h0);
      chk("abort_in_w", abort_c + 1, in_w, 32'h0);
      chk("abort_cen", abort_c + 1, 32'(sram_cen), 32'h1);
      chk("abort_addr", abort_c + 1, 32'(sram_addr), 32'h0);
      chk("abort_busy", abort_c + 1, 32'(busy), 32'h0);
      reset = 1'b0;
    end else begin
      chk("done_pulses", last, 32'(n_done), 32'h1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; w_base = '0; x_base = '0; n_x = '0; valid_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cen", 0, 32'(sram_cen), 32'h1);
    chk("rst_addr", 0, 32'(sram_addr), 32'h0);
    chk("rst_inst_w", 0, 32'(inst_w), 32'h0);
    chk("rst_in_w", 0, in_w, 32'h0);
    chk("rst_busy", 0, 32'(busy), 32'h0);
    chk("rst_done", 0, 32'(done), 32'h0);
    reset = 1'b0;

    // Basic run: weights at 0x010, activations at 0x100, four vectors.
    run(32'h010, 32'h100, 4, 4, 0, 0);
    // No activations; a start in the done cycle must be ignored.
    run(32'h040, 32'h200, 0, 0, 18, 0);
    // Activation addresses wrap past 0x7FF; start pulsed mid-EXEC.
    run(32'h020, 32'h7FE, 4, 4, 10, 0);
    // Reset raised on cycle 10, then a full clean rerun.
    run(32'h010, 32'h100, 4, 4, 0, 10);
    run(32'h010, 32'h100, 4, 4, 0, 0);
    // Six valids against four expected vectors.
    run(32'h030, 32'h180, 4, 6, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
